// File: rtl/deadtime_monitor_pkg.sv
// Shared types and constants for the dead-time monitor.
package deadtime_monitor_pkg;

    // Monitor states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        A_ON    = 3'd1,
        B_ON    = 3'd2,
        DEAD_AB = 3'd3,
        DEAD_BA = 3'd4,
        FAULT   = 3'd5
    } state_t;

    // Direction of a dead-time measurement
    localparam logic DIR_AB = 1'b0;
    localparam logic DIR_BA = 1'b1;

    // Sampled gate pair encodings, {gate_a, gate_b}
    localparam logic [1:0] GATES_OFF  = 2'b00;
    localparam logic [1:0] GATES_B    = 2'b01;
    localparam logic [1:0] GATES_A    = 2'b10;
    localparam logic [1:0] GATES_BOTH = 2'b11;

endpackage

// File: rtl/deadtime_monitor_saturating_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module saturating_counter #(
    parameter int unsigned width = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [width-1:0] count
);

    localparam logic [width-1:0] COUNT_MAX = '1;

    // Clear has priority over increment; hold at COUNT_MAX
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != COUNT_MAX)) begin
            count <= count + width'(1);
        end
    end

endmodule

// File: rtl/deadtime_monitor.sv
// Measures dead time between complementary gate commands and latches
// shoot-through / short-dead-time faults.
module deadtime_monitor
    import deadtime_monitor_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [COUNTER_WIDTH-1:0] min_deadtime,
    input  logic                     fault_clear,
    input  logic                     gate_a,
    input  logic                     gate_b,
    output logic [COUNTER_WIDTH-1:0] last_deadtime,
    output logic                     last_dir,
    output logic                     deadtime_valid,
    output logic                     shoot_through,
    output logic                     short_deadtime,
    output logic                     fault
);

    state_t                   state;
    logic                     gate_a_q;
    logic                     gate_b_q;
    logic [1:0]               sample_c;
    logic                     counter_inc_c;
    logic                     counter_clear_c;
    logic                     short_c;
    logic [COUNTER_WIDTH-1:0] count;

    // Sample stage: every decision below uses these registered copies
    always_ff @(posedge clock) begin
        if (!reset) begin
            gate_a_q <= 1'b0;
            gate_b_q <= 1'b0;
        end else begin
            gate_a_q <= gate_a;
            gate_b_q <= gate_b;
        end
    end

    assign sample_c = {gate_a_q, gate_b_q};
    assign short_c  = (count < min_deadtime);

    // Count every both-off sample that starts or extends a dead interval
    always_comb begin
        counter_inc_c = 1'b0;
        if (enable && (sample_c == GATES_OFF)) begin
            case (state)
                A_ON, B_ON, DEAD_AB, DEAD_BA: counter_inc_c = 1'b1;
                default:                      counter_inc_c = 1'b0;
            endcase
        end
    end

    assign counter_clear_c = ~counter_inc_c;

    saturating_counter #(
        .width (COUNTER_WIDTH)
    ) u_counter (
        .clock (clock),
        .reset (reset),
        .clear (counter_clear_c),
        .inc   (counter_inc_c),
        .count (count)
    );

    // Gate-sequence FSM with registered measurement and fault outputs.
    // A direct A->B (or B->A) hand-over counts as a zero-cycle dead time.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            last_deadtime  <= '0;
            last_dir       <= DIR_AB;
            deadtime_valid <= 1'b0;
            shoot_through  <= 1'b0;
            short_deadtime <= 1'b0;
            fault          <= 1'b0;
        end else begin
            deadtime_valid <= 1'b0;
            if (!enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        case (sample_c)
                            GATES_A:    state <= A_ON;
                            GATES_B:    state <= B_ON;
                            GATES_BOTH: begin
                                shoot_through <= 1'b1;
                                fault         <= 1'b1;
                                state         <= FAULT;
                            end
                            default:    state <= IDLE;
                        endcase
                    end
                    A_ON, DEAD_AB: begin
                        case (sample_c)
                            GATES_OFF:  state <= DEAD_AB;
                            GATES_A:    state <= A_ON;
                            GATES_B: begin
                                last_deadtime  <= count;
                                last_dir       <= DIR_AB;
                                deadtime_valid <= 1'b1;
                                if (short_c) begin
                                    short_deadtime <= 1'b1;
                                    fault          <= 1'b1;
                                end
                                state <= B_ON;
                            end
                            default: begin
                                shoot_through <= 1'b1;
                                fault         <= 1'b1;
                                state         <= FAULT;
                            end
                        endcase
                    end
                    B_ON, DEAD_BA: begin
                        case (sample_c)
                            GATES_OFF:  state <= DEAD_BA;
                            GATES_B:    state <= B_ON;
                            GATES_A: begin
                                last_deadtime  <= count;
                                last_dir       <= DIR_BA;
                                deadtime_valid <= 1'b1;
                                if (short_c) begin
                                    short_deadtime <= 1'b1;
                                    fault          <= 1'b1;
                                end
                                state <= A_ON;
                            end
                            default: begin
                                shoot_through <= 1'b1;
                                fault         <= 1'b1;
                                state         <= FAULT;
                            end
                        endcase
                    end
                    FAULT: begin
                        if (fault_clear && (sample_c == GATES_OFF)) begin
                            shoot_through  <= 1'b0;
                            short_deadtime <= 1'b0;
                            fault          <= 1'b0;
                            state          <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_deadtime_monitor.sv
// Scoreboard bench for deadtime_monitor: a 16-bit and a 4-bit instance
// watch the same gate stream.
module tb_deadtime_monitor;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        fault_clear;
    logic        gate_a;
    logic        gate_b;
    logic [15:0] min_dt;
    logic [3:0]  min4 = 4'd0;

    logic [15:0] last16;
    logic        dir16, valid16, shoot16, short16, fault16;
    logic [3:0]  last4;
    logic        dir4, valid4, shoot4, short4, fault4;

    always #5 clock = ~clock;

    deadtime_monitor #(.COUNTER_WIDTH(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .min_deadtime   (min_dt),
        .fault_clear    (fault_clear),
        .gate_a         (gate_a),
        .gate_b         (gate_b),
        .last_deadtime  (last16),
        .last_dir       (dir16),
        .deadtime_valid (valid16),
        .shoot_through  (shoot16),
        .short_deadtime (short16),
        .fault          (fault16)
    );

    deadtime_monitor #(.COUNTER_WIDTH(4)) dut4 (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .min_deadtime   (min4),
        .fault_clear    (fault_clear),
        .gate_a         (gate_a),
        .gate_b         (gate_b),
        .last_deadtime  (last4),
        .last_dir       (dir4),
        .deadtime_valid (valid4),
        .shoot_through  (shoot4),
        .short_deadtime (short4),
        .fault          (fault4)
    );

    typedef struct packed {
        logic [15:0] dt;
        logic        dir;
        logic        sh;
    } meas_t;

    typedef struct packed {
        logic        valid;
        logic        shoot;
        logic        short_dt;
        logic        flt;
        logic [15:0] last;
        logic        dir;
        logic [3:0]  last4;
        logic        shoot4;
        logic        fault4;
    } snap_t;

    meas_t q16[$];
    meas_t q4[$];
    snap_t snap_q[$];

    int errors = 0;
    int checks = 0;
    bit done   = 1'b0;
    int cycles = 0;

    // Hand-maintained expected state
    logic [15:0] exp_last  = 16'd0;
    logic        exp_dir   = 1'b0;
    logic [3:0]  exp_last4 = 4'd0;
    logic        exp_shoot = 1'b0;
    logic        exp_short = 1'b0;

    // Hold gates for n sampling edges; always returns at posedge+1
    task automatic drive(input logic a, input logic b, input int n);
        gate_a = a;
        gate_b = b;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input logic v);
        snap_t s;
        s.valid    = v;
        s.shoot    = exp_shoot;
        s.short_dt = exp_short;
        s.flt      = exp_shoot | exp_short;
        s.last     = exp_last;
        s.dir      = exp_dir;
        s.last4    = exp_last4;
        s.shoot4   = exp_shoot;
        s.fault4   = exp_shoot;
        snap_q.push_back(s);
    endtask

    task automatic expect_meas(input logic [15:0] dt, input logic dir,
                               input logic sh, input logic [3:0] dt4);
        meas_t m;
        m.dt = dt; m.dir = dir; m.sh = sh;
        q16.push_back(m);
        m.dt = 16'(dt4); m.dir = dir; m.sh = 1'b0;
        q4.push_back(m);
        exp_last  = dt;
        exp_dir   = dir;
        exp_last4 = dt4;
        if (sh) exp_short = 1'b1;
    endtask

    // Monitor: pop and compare on every strobe, then pending snapshots
    always @(negedge clock) begin
        meas_t m;
        meas_t act_m;
        snap_t s;
        snap_t act_s;
        cycles++;
        if (valid16) begin
            checks++;
            act_m = {last16, dir16, short16};
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL strobe16 unexpected: got dt=%0d dir=%0d short=%0d, required no strobe",
                         last16, dir16, short16);
            end else begin
                m = q16.pop_front();
                if (act_m !== m) begin
                    errors++;
                    $display("FAIL meas16: got dt=%0d dir=%0d short=%0d, required dt=%0d dir=%0d short=%0d",
                             act_m.dt, act_m.dir, act_m.sh, m.dt, m.dir, m.sh);
                end
            end
        end
        if (valid4) begin
            checks++;
            act_m = {12'd0, last4, dir4, short4};
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL strobe4 unexpected: got dt=%0d dir=%0d, required no strobe", last4, dir4);
            end else begin
                m = q4.pop_front();
                if (act_m !== m) begin
                    errors++;
                    $display("FAIL meas4: got dt=%0d dir=%0d short=%0d, required dt=%0d dir=%0d short=%0d",
                             act_m.dt, act_m.dir, act_m.sh, m.dt, m.dir, m.sh);
                end
            end
        end
        while (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            act_s = {valid16, shoot16, short16, fault16, last16, dir16, last4, shoot4, fault4};
            checks++;
            if (act_s !== s) begin
                errors++;
                $display("FAIL snapshot@%0t: got v=%0d st=%0d sd=%0d f=%0d last=%0d dir=%0d last4=%0d st4=%0d f4=%0d, required v=%0d st=%0d sd=%0d f=%0d last=%0d dir=%0d last4=%0d st4=%0d f4=%0d",
                         $time, act_s.valid, act_s.shoot, act_s.short_dt, act_s.flt, act_s.last,
                         act_s.dir, act_s.last4, act_s.shoot4, act_s.fault4,
                         s.valid, s.shoot, s.short_dt, s.flt, s.last, s.dir, s.last4, s.shoot4, s.fault4);
            end
        end
        if (done || cycles > 5000) begin
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL timeout: got %0d cycles, required completion", cycles);
            end
            checks++;
            if (q16.size() != 0) begin
                errors++;
                $display("FAIL missing16: got %0d strobes outstanding, required 0", q16.size());
            end
            checks++;
            if (q4.size() != 0) begin
                errors++;
                $display("FAIL missing4: got %0d strobes outstanding, required 0", q4.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        reset       = 1'b0;
        enable      = 1'b1;
        fault_clear = 1'b0;
        gate_a      = 1'b0;
        gate_b      = 1'b0;
        min_dt      = 16'd5;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        check(1'b0);
        reset = 1'b1;
        drive(1'b0, 1'b0, 2);
        check(1'b0);

        // A on, 8 idle cycles, B on: exact two-edge latency of the strobe
        min_dt = 16'd5;
        drive(1'b1, 1'b0, 3);
        drive(1'b0, 1'b0, 8);
        gate_a = 1'b0;
        gate_b = 1'b1;
        check(1'b0);
        @(posedge clock); #1;
        check(1'b0);
        @(posedge clock); #1;
        expect_meas(16'd8, 1'b0, 1'b0, 4'd8);
        check(1'b1);
        drive(1'b0, 1'b1, 2);
        check(1'b0);

        // B on, 4 idle cycles, A on with min 10: short dead time
        min_dt = 16'd10;
        drive(1'b0, 1'b0, 4);
        expect_meas(16'd4, 1'b1, 1'b1, 4'd4);
        drive(1'b1, 1'b0, 3);
        check(1'b0);

        // fault_clear outside FAULT is ignored
        fault_clear = 1'b1;
        drive(1'b1, 1'b0, 1);
        fault_clear = 1'b0;
        drive(1'b1, 1'b0, 2);
        check(1'b0);

        // Shoot-through, clear blocked while A high, clear with both low
        drive(1'b1, 1'b1, 1);
        drive(1'b1, 1'b0, 3);
        exp_shoot = 1'b1;
        check(1'b0);
        fault_clear = 1'b1;
        drive(1'b1, 1'b0, 1);
        fault_clear = 1'b0;
        drive(1'b1, 1'b0, 2);
        check(1'b0);
        drive(1'b0, 1'b0, 2);
        fault_clear = 1'b1;
        drive(1'b0, 1'b0, 1);
        fault_clear = 1'b0;
        exp_shoot = 1'b0;
        exp_short = 1'b0;
        check(1'b0);

        // Back in IDLE: normal B->A measurement resumes
        min_dt = 16'd2;
        drive(1'b0, 1'b1, 3);
        drive(1'b0, 1'b0, 3);
        expect_meas(16'd3, 1'b1, 1'b0, 4'd3);
        drive(1'b1, 1'b0, 3);
        check(1'b0);

        // 20 idle cycles: 4-bit instance saturates at 15
        min_dt = 16'd5;
        drive(1'b0, 1'b0, 20);
        expect_meas(16'd20, 1'b0, 1'b0, 4'd15);
        drive(1'b0, 1'b1, 3);
        check(1'b0);

        // Same gate re-asserts: no measurement
        drive(1'b0, 1'b0, 3);
        drive(1'b0, 1'b1, 3);
        check(1'b0);
        min_dt = 16'd0;
        drive(1'b0, 1'b0, 2);
        expect_meas(16'd2, 1'b1, 1'b0, 4'd2);
        drive(1'b1, 1'b0, 3);
        check(1'b0);
        drive(1'b0, 1'b0, 3);
        drive(1'b1, 1'b0, 3);
        check(1'b0);

        // Enable dropped mid dead interval: no strobe, outputs hold
        min_dt = 16'd5;
        drive(1'b0, 1'b0, 4);
        enable = 1'b0;
        drive(1'b0, 1'b0, 2);
        check(1'b0);
        enable = 1'b1;
        drive(1'b0, 1'b0, 2);
        drive(1'b0, 1'b1, 3);
        check(1'b0);
        drive(1'b0, 1'b0, 3);
        expect_meas(16'd3, 1'b1, 1'b1, 4'd3);
        drive(1'b1, 1'b0, 3);
        check(1'b0);

        // Flags hold while disabled; fault_clear has no effect then
        drive(1'b1, 1'b1, 1);
        drive(1'b1, 1'b0, 2);
        exp_shoot = 1'b1;
        check(1'b0);
        enable = 1'b0;
        drive(1'b0, 1'b0, 3);
        check(1'b0);
        fault_clear = 1'b1;
        drive(1'b0, 1'b0, 1);
        fault_clear = 1'b0;
        drive(1'b0, 1'b0, 1);
        check(1'b0);
        enable = 1'b1;

        // Reset mid dead interval: everything back to zero, no strobe
        drive(1'b1, 1'b0, 3);
        drive(1'b0, 1'b0, 5);
        reset = 1'b0;
        drive(1'b0, 1'b0, 2);
        reset = 1'b1;
        exp_shoot = 1'b0;
        exp_short = 1'b0;
        exp_last  = 16'd0;
        exp_dir   = 1'b0;
        exp_last4 = 4'd0;
        check(1'b0);
        drive(1'b0, 1'b0, 2);
        drive(1'b0, 1'b1, 3);
        check(1'b0);
        drive(1'b0, 1'b0, 6);
        expect_meas(16'd6, 1'b1, 1'b0, 4'd6);
        drive(1'b1, 1'b0, 3);
        check(1'b0);

        drive(1'b0, 1'b0, 3);
        done = 1'b1;
        repeat (5) @(posedge clock);
        $display("FAIL finish: got monitor still running, required summary");
        $fatal(1, "monitor did not finish");
    end

endmodule

// File: doc/deadtime_monitor.md
DEADTIME_MONITOR -- requirements
Module: deadtime_monitor

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 16, giving the width of the dead-time counter and measurement outputs.
REQ-002 SHALL have port clock  input  1  rising-edge system clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port enable  input  1  high = monitoring active.
REQ-005 SHALL have port min_deadtime  input  COUNTER_WIDTH  minimum legal dead time, in clock cycles.
REQ-006 SHALL have port fault_clear  input  1  single-cycle request to clear latched faults.
REQ-007 SHALL have port gate_a  input  1  observed high-side gate command.
REQ-008 SHALL have port gate_b  input  1  observed low-side gate command.
REQ-009 SHALL have port last_deadtime  output  COUNTER_WIDTH  most recent measured dead time, in cycles.
REQ-010 SHALL have port last_dir  output  1  direction of last measurement: 0 = A-to-B, 1 = B-to-A.
REQ-011 SHALL have port deadtime_valid  output  1  one-cycle strobe when last_deadtime updates.
REQ-012 SHALL have port shoot_through  output  1  latched fault: both gates high.
REQ-013 SHALL have port short_deadtime  output  1  latched fault: measured dead time below min_deadtime.
REQ-014 SHALL have port fault  output  1  OR of shoot_through and short_deadtime.

Function
REQ-015 SHALL register gate_a and gate_b once (sample stage); all decisions use the sampled values.
REQ-016 SHALL implement FSM states IDLE, A_ON, B_ON, DEAD_AB, DEAD_BA, FAULT.
REQ-017 In IDLE, SHALL go to A_ON on sample (1,0), to B_ON on (0,1), and SHALL stay in IDLE on (0,0).
REQ-018 In A_ON, on sample (0,0) SHALL go to DEAD_AB with counter=1; in B_ON, on sample (0,0) SHALL go to DEAD_BA with counter=1.
REQ-019 In DEAD_xx, each further (0,0) sample SHALL increment the counter, saturating at all-ones (no wrap).
REQ-020 In DEAD_AB, on sample (0,1) the block SHALL latch last_deadtime=counter and last_dir=0, pulse deadtime_valid for one cycle, and go to B_ON; DEAD_BA SHALL behave symmetrically on (1,0), with last_dir=1 and next state A_ON.
REQ-021 In DEAD_AB, sample (1,0) (same gate re-asserts) SHALL go to A_ON with no measurement and no strobe; DEAD_BA SHALL behave symmetrically.
REQ-022 With a measurement, if counter < min_deadtime (unsigned), short_deadtime SHALL set in the same cycle as deadtime_valid.
REQ-023 Sample (1,1) in any state except FAULT SHALL set shoot_through and go to FAULT; if this coincides with a dead-time end, no measurement SHALL occur.
REQ-024 Latency: a gate input change SHALL be reflected on the outputs exactly 2 clock edges later.
REQ-025 In FAULT, the block SHALL stay until fault_clear=1 while sample=(0,0), then clear both fault flags and go to IDLE.
REQ-026 fault_clear outside FAULT, or while any gate is high, SHALL have no effect.
REQ-027 When enable=0, the block SHALL force IDLE, clear the counter, and suppress strobes; fault flags and last_deadtime SHALL hold.
REQ-028 min_deadtime=0 SHALL never flag short_deadtime.

Reset
REQ-029 While reset=0 at a clock edge: state=IDLE, counter=0, sample registers=0, last_deadtime=0, last_dir=0, deadtime_valid=0, shoot_through=0, short_deadtime=0, fault=0.
REQ-030 Reset asserted mid-measurement SHALL discard the measurement; monitoring SHALL restart from IDLE.

Structure
REQ-031 The state enum and direction constants (DIR_AB=0, DIR_BA=1) SHALL live in package deadtime_monitor_pkg.
REQ-032 The counter SHALL be a sub-module, saturating_counter (parameter width; ports clock, reset, clear, inc, count).
REQ-033 The implementation SHALL be single-clock with no combinational path from inputs to outputs.

Verification
REQ-034 Scenario: min=5; A high, then 8 cycles both low, then B high -> last_deadtime=8, last_dir=0, one valid strobe, fault=0.
REQ-035 Scenario: min=10; B high, then 4 cycles both low, then A high -> last_deadtime=4, last_dir=1, short_deadtime=1, fault=1.
REQ-036 Scenario: A and B high together for 1 cycle -> shoot_through=1, FAULT state; fault_clear with A high -> no change; fault_clear with both low -> flags=0, IDLE.
REQ-037 Scenario: COUNTER_WIDTH=4; 20 cycles dead between A and B -> last_deadtime=15, no wrap.
REQ-038 Scenario: A falls for 3 cycles, then A rises again -> no strobe, last_deadtime unchanged.
REQ-039 Scenario: reset pulsed during a dead interval, or enable dropped during one -> no strobe; all outputs per REQ-029 (reset) or held (enable).
